pool_flatten_engine: RTL

Parametrised max-pool / ReLU / flatten engine that post-processes the layer-0 convolution banks of the CONV datapath. It reads `CH` layer-0 feature maps of `IMG_W`×`IMG_W` through the shared `crd`/`cwr`/`csel` memory port. For each map it writes a 2×2/stride-2 max-pooled layer-1 map and, optionally, a channel-interleaved layer-2 flatten vector. Compared with the fixed 64×64, two-kernel pooling stage, it adds configurable image size, configurable channel count, signed compare, and runtime ReLU and flatten enables.

---
 rtl/pool_flatten_engine.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/pool_flatten_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pool_flatten_engine                                              |
// | Brief    : 2x2/stride-2 signed max-pool with optional ReLU and flatten      |
// |            over CH layer-0 banks, through a shared single-port memory bus.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module pool_flatten_engine #(
  parameter int DATA_W = 20,
  parameter int IMG_W  = 64,
  parameter int CH     = 2,
  parameter int ADDR_W = 12,
  parameter int CSEL_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              flat_en,
  input  logic              relu_en,
  output logic              busy,
  output logic              done,
  output logic              crd,
  output logic [ADDR_W-1:0] caddr_rd,
  input  logic [DATA_W-1:0] cdata_rd,
  output logic              cwr,
  output logic [ADDR_W-1:0] caddr_wr,
  output logic [DATA_W-1:0] cdata_wr,
  output logic [CSEL_W-1:0] csel
);

  localparam int c_HALF = IMG_W / 2;
  localparam int c_HB   = $clog2(c_HALF);

  localparam logic [2:0] c_IDLE = 3'd0;
  localparam logic [2:0] c_RD   = 3'd1;
  localparam logic [2:0] c_CAP  = 3'd2;
  localparam logic [2:0] c_WL1  = 3'd3;
  localparam logic [2:0] c_WL2  = 3'd4;
  localparam logic [2:0] c_FIN  = 3'd5;

  localparam logic [CSEL_W-1:0] c_SEL_L0  = CSEL_W'(1);
  localparam logic [CSEL_W-1:0] c_SEL_L1  = CSEL_W'(1 + CH);
  localparam logic [CSEL_W-1:0] c_SEL_L2  = CSEL_W'(1 + 2 * CH);
  localparam logic [1:0]        c_CH_LAST = 2'(CH - 1);

  logic [2:0]        r_state;
  logic [1:0]        r_k;
  logic [c_HB-1:0]   r_px;
  logic [c_HB-1:0]   r_py;
  logic [1:0]        r_ch;
  logic [ADDR_W-1:0] r_l2_addr;
  logic              r_flat;
  logic              r_relu;
  logic [DATA_W-1:0] r_acc;

  logic              r_busy;
  logic              r_done;
  logic              r_crd;
  logic [ADDR_W-1:0] r_caddr_rd;
  logic              r_cwr;
  logic [ADDR_W-1:0] r_caddr_wr;
  logic [DATA_W-1:0] r_cdata_wr;
  logic [CSEL_W-1:0] r_csel;

  logic              w_last_ch;
  logic              w_last;
  logic [1:0]        w_nxt_ch;
  logic [c_HB-1:0]   w_nxt_px;
  logic [c_HB-1:0]   w_nxt_py;
  logic [1:0]        w_k_nxt;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [ADDR_W-1:0] w_nxt_base;
  logic [ADDR_W-1:0] w_pix;
  logic              w_sample_gt;
  logic [DATA_W-1:0] w_result;
  logic              w_adv;

  assign w_last_ch = (r_ch == c_CH_LAST);
  assign w_last    = w_last_ch && (&r_px) && (&r_py);
  assign w_nxt_ch  = w_last_ch ? 2'd0 : r_ch + 2'd1;
  assign w_nxt_px  = w_last_ch ? r_px + c_HB'(1) : r_px;
  assign w_nxt_py  = (w_last_ch && (&r_px)) ? r_py + c_HB'(1) : r_py;
  assign w_k_nxt   = r_k + 2'd1;

  // Address {py, dy, px, dx} equals (2py+dy)*IMG_W + 2px+dx since IMG_W is a power of two.
  assign w_rd_addr  = ADDR_W'({r_py, w_k_nxt[1], r_px, w_k_nxt[0]});
  assign w_nxt_base = ADDR_W'({w_nxt_py, 1'b0, w_nxt_px, 1'b0});
  assign w_pix      = ADDR_W'({r_py, r_px});

  assign w_sample_gt = $signed(cdata_rd) > $signed(r_acc);
  assign w_result    = (r_relu && r_acc[DATA_W-1]) ? '0 : r_acc;

  // Last write of a (pixel, channel) pair also advances the loop counters.
  assign w_adv = (r_state == c_WL2) || ((r_state == c_WL1) && !r_flat);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= c_IDLE;
      r_k        <= '0;
      r_px       <= '0;
      r_py       <= '0;
      r_ch       <= '0;
      r_l2_addr  <= '0;
      r_flat     <= 1'b0;
      r_relu     <= 1'b0;
      r_acc      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_crd      <= 1'b0;
      r_caddr_rd <= '0;
      r_cwr      <= 1'b0;
      r_caddr_wr <= '0;
      r_cdata_wr <= '0;
      r_csel     <= '0;
    end else begin
      r_crd  <= 1'b0;
      r_cwr  <= 1'b0;
      r_csel <= '0;
      r_done <= 1'b0;

      case (r_state)
        c_IDLE: begin
          if (start) begin
            r_flat     <= flat_en;
            r_relu     <= relu_en;
            r_k        <= '0;
            r_px       <= '0;
            r_py       <= '0;
            r_ch       <= '0;
            r_l2_addr  <= '0;
            r_busy     <= 1'b1;
            r_crd      <= 1'b1;
            r_caddr_rd <= '0;
            r_csel     <= c_SEL_L0;
            r_state    <= c_RD;
          end
        end
        c_RD: begin
          if ((r_k == 2'd0) || w_sample_gt) begin
            r_acc <= cdata_rd;
          end
          if (r_k == 2'd3) begin
            r_k     <= '0;
            r_state <= c_CAP;
          end else begin
            r_k        <= w_k_nxt;
            r_crd      <= 1'b1;
            r_csel     <= c_SEL_L0 + CSEL_W'(r_ch);
            r_caddr_rd <= w_rd_addr;
          end
        end
        c_CAP: begin
          r_cwr      <= 1'b1;
          r_csel     <= c_SEL_L1 + CSEL_W'(r_ch);
          r_caddr_wr <= w_pix;
          r_cdata_wr <= w_result;
          r_state    <= c_WL1;
        end
        c_WL1: begin
          if (r_flat) begin
            r_cwr      <= 1'b1;
            r_csel     <= c_SEL_L2;
            r_caddr_wr <= r_l2_addr;
            r_state    <= c_WL2;
          end
        end
        c_WL2: begin
          r_state <= c_IDLE;
        end
        c_FIN: begin
          r_state <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase

      if (w_adv) begin
        r_ch      <= w_nxt_ch;
        r_px      <= w_nxt_px;
        r_py      <= w_nxt_py;
        r_l2_addr <= r_l2_addr + ADDR_W'(1);
        if (w_last) begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= c_FIN;
        end else begin
          r_k        <= '0;
          r_crd      <= 1'b1;
          r_csel     <= c_SEL_L0 + CSEL_W'(w_nxt_ch);
          r_caddr_rd <= w_nxt_base;
          r_state    <= c_RD;
        end
      end
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign crd      = r_crd;
  assign caddr_rd = r_caddr_rd;
  assign cwr      = r_cwr;
  assign caddr_wr = r_caddr_wr;
  assign cdata_wr = r_cdata_wr;
  assign csel     = r_csel;

endmodule
`default_nettype wire
